// File: rtl/quad_enc_gen.sv
// quad_enc_gen: MMIO-programmed quadrature A/B generator.
// Emits N Gray-code transitions at a programmable spacing and tracks a signed position count.
module quad_enc_gen #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        qa,
    output logic        qb
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_n;
    logic [PERIOD_W-1:0] period_q, period_n;
    logic [PERIOD_W-1:0] timer, timer_n;
    logic [CNT_W-1:0]    remaining, remaining_n;
    logic                dir, dir_n;
    logic [1:0]          phase, phase_n;
    logic [31:0]         position, position_n;
    logic                done, done_n;
    logic                aborted, aborted_n;

    logic                wr_period, wr_move, wr_ctrl;
    logic [PERIOD_W-1:0] period_in;
    logic [CNT_W-1:0]    move_cnt;
    logic [1:0]          step_phase;
    logic [15:0]         rem16;
    logic                busy;
    logic                unused_in;

    assign wr_period = cs && write && (addr[1:0] == 2'd0);
    assign wr_move   = cs && write && (addr[1:0] == 2'd1);
    assign wr_ctrl   = cs && write && (addr[1:0] == 2'd2);
    assign period_in = wr_data[PERIOD_W-1:0];
    assign move_cnt  = wr_data[CNT_W-1:0];
    assign busy      = (state == RUN);
    assign rem16     = 16'(remaining);
    assign unused_in = ^{read, addr[4:2], wr_data};

    // phase is {qa,qb}; forward rotates 00->10->11->01, reverse the other way
    assign step_phase = dir ? {~phase[0], phase[1]} : {phase[0], ~phase[1]};

    always_comb begin
        state_n     = state;
        period_n    = period_q;
        timer_n     = timer;
        remaining_n = remaining;
        dir_n       = dir;
        phase_n     = phase;
        position_n  = position;
        done_n      = done;
        aborted_n   = aborted;

        if (wr_period) begin
            period_n = (period_in < PERIOD_W'(2)) ? PERIOD_W'(2) : period_in;
        end

        unique case (state)
            IDLE: begin
                if (wr_move) begin
                    aborted_n = 1'b0;
                    if (move_cnt != '0) begin
                        remaining_n = move_cnt;
                        timer_n     = period_q - PERIOD_W'(1);
                        dir_n       = wr_data[31];
                        done_n      = 1'b0;
                        state_n     = RUN;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort freezes everything, including a step due this cycle
                if (wr_ctrl && wr_data[0]) begin
                    state_n   = IDLE;
                    aborted_n = 1'b1;
                    done_n    = 1'b0;
                end else if (timer == '0) begin
                    phase_n     = step_phase;
                    position_n  = dir ? position + 32'd1 : position - 32'd1;
                    remaining_n = remaining - CNT_W'(1);
                    timer_n     = period_q - PERIOD_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    timer_n = timer - PERIOD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (wr_ctrl && wr_data[1]) begin
            position_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            period_q  <= PERIOD_W'(2);
            timer     <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            phase     <= 2'b00;
            position  <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            period_q  <= period_n;
            timer     <= timer_n;
            remaining <= remaining_n;
            dir       <= dir_n;
            phase     <= phase_n;
            position  <= position_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

    assign qa = phase[1];
    assign qb = phase[0];

    always_comb begin
        rd_data = '0;
        unique case (addr[1:0])
            2'd0: rd_data = {busy, done, aborted, 13'b0, rem16};
            2'd1: rd_data = position;
            2'd2: rd_data = 32'(period_q);
            2'd3: rd_data = '0;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Testbench for quad_enc_gen: table of moves plus hand-timed corner sequences.
// Expected transitions are queued when a move is issued and checked as qa/qb change.
module tb_quad_enc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        qa, qb;

    quad_enc_gen #(.PERIOD_W(24), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .qa(qa), .qb(qb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] ph;
    } step_t;

    typedef struct {
        logic        clr;
        logic [31:0] per_wr;
        int          per;
        logic        dir;
        int          n;
        logic [1:0]  ph;
        logic [31:0] pos;
    } vec_t;

    step_t       sb[$];
    step_t       e;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  m_ph = 2'b00;
    logic [31:0] m_pos = 32'd0;
    logic        mon_en = 1'b0;
    logic [1:0]  prev = 2'b00;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] nxt(logic [1:0] p, logic d);
        logic [1:0] seq [4];
        int i;
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        i = 0;
        for (int k = 0; k < 4; k++) if (seq[k] == p) i = k;
        return d ? seq[(i + 1) % 4] : seq[(i + 3) % 4];
    endfunction

    function automatic void expect_step(int at, logic d, logic clr);
        step_t s;
        m_ph  = nxt(m_ph, d);
        m_pos = clr ? 32'd0 : (d ? m_pos + 32'd1 : m_pos - 32'd1);
        s.at  = at;
        s.ph  = m_ph;
        sb.push_back(s);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if ({qa, qb} !== prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL toggle: unexpected phase %b at cycle %0d", {qa, qb}, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("step_cycle", cyc, e.at);
                    chk("step_phase", {30'd0, qa, qb}, {30'd0, e.ph});
                end
            end else if (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL step_missing: no change at cycle %0d want %b", e.at, e.ph);
            end
        end
        prev = {qa, qb};
    end

    task automatic go(int x);
        if (cyc > x) begin
            errors++;
            $display("FAIL schedule: at cycle %0d want %0d", cyc, x);
        end
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d, output int t);
        t = cyc;
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic move(int per, logic d, int n, int clr_k, output int t);
        wr(5'd1, {d, 15'd0, 16'(n)}, t);
        for (int k = 0; k < n; k++) expect_step(t + per + 1 + k * per, d, k == clr_k);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d steps still pending", sb.size());
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    vec_t        vecs[5];
    logic [31:0] d;
    int          t, tw;

    initial begin
        vecs[0] = '{1'b0, 32'd4, 4, 1'b1, 8, 2'b00, 32'd8};
        vecs[1] = '{1'b1, 32'd2, 2, 1'b0, 3, 2'b10, 32'hFFFF_FFFD};
        vecs[2] = '{1'b0, 32'd2, 2, 1'b1, 3, 2'b00, 32'd0};
        vecs[3] = '{1'b0, 32'd0, 2, 1'b1, 1, 2'b10, 32'd1};
        vecs[4] = '{1'b0, 32'd3, 3, 1'b0, 5, 2'b00, 32'hFFFF_FFFC};

        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", {30'd0, qa, qb}, 32'd0);
        rd(5'd0, d); chk("reset_status", d, 32'd0);
        rd(5'd1, d); chk("reset_pos", d, 32'd0);
        rd(5'd2, d); chk("reset_period", d, 32'd2);
        rd(5'd3, d); chk("reset_rd3", d, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].clr) begin
                wr(5'd2, 32'd2, tw);
                m_pos = 32'd0;
            end
            wr(5'd0, vecs[i].per_wr, tw);
            rd(5'd2, d); chk("vec_period", d, 32'(vecs[i].per));
            move(vecs[i].per, vecs[i].dir, vecs[i].n, -1, t);
            rd(5'd0, d); chk("vec_busy", {31'd0, d[31]}, 32'd1);
            drain();
            rd(5'd0, d); chk("vec_status", d, 32'h4000_0000);
            rd(5'd1, d); chk("vec_pos", d, vecs[i].pos);
            chk("vec_phase", {30'd0, qa, qb}, {30'd0, vecs[i].ph});
        end

        // MOVE written while running must be ignored
        wr(5'd0, 32'd2, tw);
        move(2, 1'b1, 6, -1, t);
        go(t + 2);
        wr(5'd1, {1'b0, 15'd0, 16'd50}, tw);
        go(t + 4);
        rd(5'd0, d); chk("busy_write_rem", d, 32'h8000_0005);
        drain();
        rd(5'd1, d); chk("busy_write_pos", d, m_pos);

        // clear-position coinciding with the second step
        wr(5'd0, 32'd4, tw);
        move(4, 1'b1, 4, 1, t);
        go(t + 8);
        wr(5'd2, 32'd2, tw);
        rd(5'd1, d); chk("clear_on_step", d, 32'd0);
        drain();
        rd(5'd1, d); chk("clear_final_pos", d, 32'd2);

        // PERIOD rewrite mid-move: spacing changes after the following step
        wr(5'd0, 32'd4, tw);
        wr(5'd1, {1'b1, 15'd0, 16'd4}, t);
        expect_step(t + 5, 1'b1, 1'b0);
        expect_step(t + 9, 1'b1, 1'b0);
        expect_step(t + 15, 1'b1, 1'b0);
        expect_step(t + 21, 1'b1, 1'b0);
        go(t + 6);
        wr(5'd0, 32'd6, tw);
        drain();
        rd(5'd2, d); chk("period_mid", d, 32'd6);
        rd(5'd1, d); chk("period_mid_pos", d, m_pos);

        // abort after 5 of 100, then N=0, then resume from frozen phase
        wr(5'd0, 32'd10, tw);
        wr(5'd1, {1'b1, 15'd0, 16'd100}, t);
        for (int k = 0; k < 5; k++) expect_step(t + 11 + 10 * k, 1'b1, 1'b0);
        go(t + 55);
        wr(5'd2, 32'd1, tw);
        go(t + 57);
        rd(5'd0, d); chk("abort_status", d, 32'h2000_005F);
        go(t + 90);
        rd(5'd1, d); chk("abort_pos", d, m_pos);
        chk("abort_phase", {30'd0, qa, qb}, {30'd0, m_ph});
        wr(5'd1, {1'b1, 15'd0, 16'd0}, tw);
        rd(5'd0, d); chk("zero_move_flags", {29'd0, d[31:29]}, 32'd2);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        move(10, 1'b1, 2, -1, t);
        drain();
        rd(5'd1, d); chk("resume_pos", d, m_pos);
        chk("resume_phase", {30'd0, qa, qb}, {30'd0, m_ph});

        // asynchronous reset in the middle of a move
        wr(5'd0, 32'd2, tw);
        move(2, 1'b0, 50, -1, t);
        go(t + 20);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_run_q", {30'd0, qa, qb}, 32'd0);
        rd(5'd0, d); chk("rst_run_status", d, 32'd0);
        rd(5'd1, d); chk("rst_run_pos", d, 32'd0);
        rd(5'd2, d); chk("rst_run_period", d, 32'd2);
        sb.delete();
        m_ph = 2'b00;
        m_pos = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        go(cyc + 30);
        chk("rst_run_quiet", {30'd0, qa, qb}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_enc_gen.md
# quad_enc_gen

Quadrature signal generator slot core: the transmit-side counterpart of the rotary-encoder input core. Software programs a step period, a direction and a number of quadrature transitions. The block then drives A/B outputs on a Pmod header with the standard Gray-code sequence, tracking a signed position count. It sits on the MMIO slot bus beside the encoder input core and is used to drive encoder-input logic or external quadrature consumers in loopback tests.

## Interface
- PERIOD_W, 24, width of the period register (clock cycles per transition)
- CNT_W, 16, width of the step-count field
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  slot select
- read  in  1  read strobe (status only; reads have no side effects)
- write  in  1  write strobe; a write takes effect when cs && write
- addr  in  5  register address; only addr[1:0] is decoded, addr[4:2] is ignored
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational mux on addr
- qa  out  1  quadrature channel A, registered
- qb  out  1  quadrature channel B, registered

## Operation
- Registers (write):
  - addr 0 PERIOD: wr_data[PERIOD_W-1:0]; values < 2 are stored as 2. Reset value 2.
  - addr 1 MOVE: bit31 = dir (1 = forward), bits[CNT_W-1:0] = N transitions. Accepted only in IDLE; ignored while RUN.
  - addr 2 CTRL: bit0 = abort (self-clearing), bit1 = clear position.
- Registers (read):
  - addr 0: {busy[31], done[30], aborted[29], 13'b0, remaining[15:0]}
  - addr 1: position, 32-bit two's complement
  - addr 2: stored PERIOD, zero-extended
  - addr 3: 0
- Phase sequence, as {qa,qb}:
  - forward: 00→10→11→01→00 (A leads B)
  - reverse: the inverse order
  - Exactly one output changes per transition.
- Position changes by +1 per forward transition and −1 per reverse transition, wrapping mod 2^32.
- FSM IDLE:
  - On an accepted MOVE with N > 0: load remaining = N and timer = PERIOD−1, latch dir, clear done and aborted, go to RUN.
  - On MOVE with N = 0: set done, clear aborted, stay IDLE; outputs unchanged.
- FSM RUN:
  - Each cycle the timer decrements.
  - When timer == 0: advance phase, update position, decrement remaining, reload timer = PERIOD−1.
  - If remaining was 1, go to IDLE and set done.
- Abort (CTRL bit0 while RUN): go to IDLE next cycle, set aborted, leave done clear. qa/qb hold the current phase and remaining holds its value. Abort in IDLE has no effect.
- Clear position (CTRL bit1):
  - Forces position to 0.
  - If it coincides with a step, the clear wins: position = 0.
- A PERIOD write during RUN updates the stored value; it takes effect at the next timer reload.
- The phase persists across moves: a new move continues from the current {qa,qb}, with no glitch or reset to 00.

## Timing
- Reset values:
  - qa = qb = 0, phase 00, position 0, PERIOD 2, remaining 0, state IDLE
  - busy = done = aborted = 0
- With a MOVE write in cycle T:
  - busy = 1 from T+1.
  - The first qa/qb change is visible at T+PERIOD+1.
  - Subsequent changes follow every PERIOD cycles.
- The last transition and busy = 0 / done = 1 appear in the same cycle.
- position and remaining update in the same cycle as qa/qb.
- Asynchronous reset mid-move returns all state to reset values immediately; no further transitions occur.

## Test plan
- Reset: assert reset during RUN -> qa = qb = 0, position = 0, rd addr0 = 0, no toggles afterward.
- Forward move: PERIOD = 4, MOVE {dir=1, N=8} -> {qa,qb} = 10, 11, 01, 00, 10, 11, 01, 00 at cycles T+5, T+9, … T+33; position = 8; done = 1 at T+33; busy = 0.
- Reverse and wrap: from position 0, PERIOD = 2, MOVE {dir=0, N=3} -> sequence 01, 11, 10; position = 0xFFFFFFFD; then forward N=3 returns position to 0 and phase to 00.
- Abort and resume:
  - PERIOD = 10, N = 100; abort after 5 transitions -> aborted = 1, done = 0, remaining = 95, outputs frozen.
  - A subsequent MOVE continues from the frozen phase.
- Busy-write and edge cases:
  - MOVE written during RUN is ignored (remaining unaffected).
  - N = 0 sets done with no toggles.
  - PERIOD = 0 reads back 2, giving transitions every 2 cycles.
- Simultaneous events: clear-position in the same cycle as a step -> position = 0; a PERIOD write mid-move changes spacing only after the next transition.
